// File: rtl/gnrl_pkg.sv
// Shared definitions for the bipolar burst generator: FSM state encoding and
// default widths.
package gnrl_pkg;

  localparam int TIME_WIDTH_DEF = 16;
  localparam int NCYC_WIDTH_DEF = 8;

  // One-hot so each phase decodes from a single bit.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    PH1   = 5'b00010,
    DEAD1 = 5'b00100,
    PH2   = 5'b01000,
    DEAD2 = 5'b10000
  } state_t;

endpackage

// File: rtl/gnrl_phase_timer.sv
// Loadable down-counter that times each burst phase.
// It holds at zero and flags ZERO when it gets there.
module gnrl_phase_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] VALUE,
  output logic             ZERO
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (LOAD) begin
      count <= VALUE;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign ZERO = (count == '0);

endmodule

// File: rtl/gnrl_bipolar_burst_gen.sv
// Bipolar transmit-burst generator: turns a one-cycle fire pulse into NUM_CYC
// periods of first-phase / dead / second-phase / dead on the P/N gate drives.
module gnrl_bipolar_burst_gen
  import gnrl_pkg::*;
#(
  parameter int TIME_WIDTH = TIME_WIDTH_DEF,
  parameter int NCYC_WIDTH = NCYC_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TRIG,
  input  logic [TIME_WIDTH-1:0] HALF_PER,
  input  logic [TIME_WIDTH-1:0] DEAD_TIME,
  input  logic [NCYC_WIDTH-1:0] NUM_CYC,
  input  logic                  INV_POL,
  output logic                  PULSE_P,
  output logic                  PULSE_N,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  MISSED_TRIG,
  output logic [4:0]            STATE
);

  state_t state_q, state_d;

  logic [TIME_WIDTH-1:0] half_q, dead_q;
  logic [NCYC_WIDTH-1:0] ncyc_q, cnt_q, cnt_d;
  logic                  inv_q;
  logic                  empty_q, empty_d;
  logic                  latch;
  logic                  inv_eff;
  logic                  period_end;

  logic p_q, n_q, busy_q, done_q, missed_q;
  logic p_d, n_d, busy_d, done_d, missed_d;

  logic                  tmr_load;
  logic [TIME_WIDTH-1:0] tmr_value;
  logic                  tmr_zero;

  logic [TIME_WIDTH-1:0] half_m1, half_in_m1, dead_m1;

  // A zero half-period still drives each polarity for one cycle.
  assign half_m1    = (half_q == '0) ? '0 : TIME_WIDTH'(half_q - 1'b1);
  assign half_in_m1 = (HALF_PER == '0) ? '0 : TIME_WIDTH'(HALF_PER - 1'b1);
  assign dead_m1    = TIME_WIDTH'(dead_q - 1'b1);

  gnrl_phase_timer #(
    .WIDTH(TIME_WIDTH)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (tmr_load),
    .VALUE (tmr_value),
    .ZERO  (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    empty_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    missed_d   = TRIG & busy_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    latch      = 1'b0;
    inv_eff    = inv_q;
    period_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        // empty_q marks the single busy cycle of a NUM_CYC==0 shot.
        if (empty_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (TRIG) begin
          latch   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          inv_eff = INV_POL;
          if (NUM_CYC != '0) begin
            state_d   = PH1;
            tmr_load  = 1'b1;
            tmr_value = half_in_m1;
          end else begin
            empty_d = 1'b1;
          end
        end
      end
      PH1: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (dead_q != '0) begin
            state_d   = DEAD1;
            tmr_value = dead_m1;
          end else begin
            state_d   = PH2;
            tmr_value = half_m1;
          end
        end
      end
      DEAD1: begin
        if (tmr_zero) begin
          state_d   = PH2;
          tmr_load  = 1'b1;
          tmr_value = half_m1;
        end
      end
      PH2: begin
        if (tmr_zero) begin
          if (dead_q != '0) begin
            state_d   = DEAD2;
            tmr_load  = 1'b1;
            tmr_value = dead_m1;
          end else begin
            period_end = 1'b1;
          end
        end
      end
      DEAD2: begin
        if (tmr_zero) period_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (period_end) begin
      cnt_d    = NCYC_WIDTH'(cnt_q + 1'b1);
      tmr_load = 1'b1;
      if (cnt_d == ncyc_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d   = PH1;
        tmr_value = half_m1;
      end
    end

    // Both drives decode from the next state, so they can never overlap.
    p_d = ((state_d == PH1) & ~inv_eff) | ((state_d == PH2) & inv_eff);
    n_d = ((state_d == PH1) & inv_eff) | ((state_d == PH2) & ~inv_eff);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      empty_q  <= 1'b0;
      half_q   <= '0;
      dead_q   <= '0;
      ncyc_q   <= '0;
      inv_q    <= 1'b0;
      p_q      <= 1'b0;
      n_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      p_q      <= p_d;
      n_q      <= n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      missed_q <= missed_d;
      if (latch) begin
        half_q <= HALF_PER;
        dead_q <= DEAD_TIME;
        ncyc_q <= NUM_CYC;
        inv_q  <= INV_POL;
      end
    end
  end

  assign PULSE_P     = p_q;
  assign PULSE_N     = n_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign MISSED_TRIG = missed_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_gnrl_bipolar_burst_gen.sv
// Bench for gnrl_bipolar_burst_gen: expected per-cycle output vectors are queued
// when a trigger is driven and compared cycle by cycle on the falling edge.
module tb_gnrl_bipolar_burst_gen;

  localparam int TW = 12;
  localparam int NW = 8;

  // Vector layout: {missed, done, busy, n, p}
  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_BUSY = 5'b00100;
  localparam logic [4:0] V_P    = 5'b00101;
  localparam logic [4:0] V_N    = 5'b00110;
  localparam logic [4:0] V_DONE = 5'b01000;
  localparam logic [4:0] V_MISS = 5'b10000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic [TW-1:0] half_per = '0;
  logic [TW-1:0] dead_time = '0;
  logic [NW-1:0] num_cyc = '0;
  logic          inv_pol = 1'b0;
  logic          pulse_p, pulse_n, busy, done, missed;
  logic [4:0]    state;

  logic [4:0] exp_q[$];
  int         n_checks = 0;
  int         n_errs = 0;
  bit         mon_en = 1'b0;

  gnrl_bipolar_burst_gen #(
    .TIME_WIDTH(TW),
    .NCYC_WIDTH(NW)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .TRIG        (trig),
    .HALF_PER    (half_per),
    .DEAD_TIME   (dead_time),
    .NUM_CYC     (num_cyc),
    .INV_POL     (inv_pol),
    .PULSE_P     (pulse_p),
    .PULSE_N     (pulse_n),
    .BUSY        (busy),
    .DONE        (done),
    .MISSED_TRIG (missed),
    .STATE       (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Scoreboard: one expected vector per cycle, idle when the queue is empty.
  always @(negedge clk) begin
    logic [4:0] exp;
    if (mon_en) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : V_IDLE;
      check("outputs", {missed, done, busy, pulse_n, pulse_p}, exp);
      check("p_n_excl", pulse_p & pulse_n, 0);
    end
  end

  // Drivers: all are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_q(input int lim);
    int i = 0;
    while (exp_q.size() > lim && i < 20000) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (exp_q.size() > lim) check("drain_timeout", exp_q.size(), lim);
  endtask

  task automatic fire(input int h, input int d, input int n, input bit inv);
    int         hh;
    logic [4:0] first, second;
    if (exp_q.size() == 0) exp_q.push_back(V_IDLE);
    half_per  = TW'(h);
    dead_time = TW'(d);
    num_cyc   = NW'(n);
    inv_pol   = inv;
    trig      = 1'b1;
    hh     = (h == 0) ? 1 : h;
    first  = inv ? V_N : V_P;
    second = inv ? V_P : V_N;
    if (n == 0) begin
      exp_q.push_back(V_BUSY);
    end else begin
      for (int c = 0; c < n; c++) begin
        repeat (hh) exp_q.push_back(first);
        repeat (d) exp_q.push_back(V_BUSY);
        repeat (hh) exp_q.push_back(second);
        repeat (d) exp_q.push_back(V_BUSY);
      end
    end
    exp_q.push_back(V_DONE);
    @(posedge clk);
    #1;
    trig = 1'b0;
  endtask

  // A trigger while busy: only MISSED_TRIG in the following cycle changes.
  task automatic poke_trig();
    if (exp_q.size() >= 2) exp_q[1] = exp_q[1] | V_MISS;
    trig = 1'b1;
    @(posedge clk);
    #1;
    trig = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_outputs", {missed, done, busy, pulse_n, pulse_p}, 0);
    check("rst_state", state, 5'b00001);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Basic burst: P 4, dead 2, N 4, dead 2, three periods
    fire(4, 2, 3, 0);
    wait_q(0);
    idle(2);

    // Inverted, single-cycle phases, no dead time
    fire(1, 0, 2, 1);
    wait_q(0);

    // Empty shots, including HALF_PER=0 and a trigger during the busy cycle
    fire(3, 1, 0, 0);
    wait_q(0);
    fire(0, 0, 0, 1);
    poke_trig();
    wait_q(0);
    fire(0, 2, 2, 0);
    wait_q(0);

    // Missed trigger and settings rewritten mid-burst, then back-to-back shot
    fire(4, 2, 3, 0);
    idle(1);
    num_cyc  = 8'd7;
    half_per = 12'd9;
    inv_pol  = 1'b1;
    idle(3);
    poke_trig();
    wait_q(1);
    fire(2, 1, 2, 1);
    wait_q(0);

    // Asynchronous reset in the middle of PH1
    fire(4, 2, 3, 0);
    idle(1);
    #2;
    rst = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    #1;
    check("rst_async", {done, busy, pulse_n, pulse_p}, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", {missed, done, busy, pulse_n, pulse_p}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);
    fire(4, 2, 3, 0);
    wait_q(0);

    // Extremes: maximum period count, maximum half period
    fire(1, 0, 255, 0);
    wait_q(0);
    fire((1 << TW) - 1, 0, 1, 0);
    wait_q(0);

    // Random shots with random mid-burst input churn
    for (int i = 0; i < 8; i++) begin
      fire($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      idle(1);
      half_per  = TW'($urandom_range(0, 7));
      dead_time = TW'($urandom_range(0, 7));
      num_cyc   = NW'($urandom_range(0, 7));
      wait_q(0);
      idle($urandom_range(0, 3));
    end

    idle(3);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
